// File: rtl/sp_ram_be.sv
// Single-port RAM with byte write enables, selectable read-during-write mode,
// optional output register and a post-reset clear engine. Parity: SP_RAM_PARITY_EN.
module sp_ram_be #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  localparam int NB        = DATA_WIDTH / BYTE_WIDTH,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  par_inj,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_err,
  output logic                  busy
);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdWord, mergedWord, memWdata;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memWe, access, rdPerr;

  logic [DATA_WIDTH-1:0] s1Data_q, s1Data_d;
  logic                  s1Valid_q, s1Valid_d, s1Perr_q, s1Perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear sweeps every address once, then the FSM parks in READY until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (&ptr_q) state_d = READY;
    end
  end

  always_comb begin
    busy = (state_q == CLEAR);
  end

  assign access = en & ~busy;
  assign rdWord = mem[addr];

  always_comb begin
    mergedWord = rdWord;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mergedWord[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // The clear engine owns the write port while busy; it idles while rst is held.
  always_comb begin
    memWe    = 1'b0;
    memAddr  = addr;
    memWdata = mergedWord;
    if (busy) begin
      memWe    = ~rst;
      memAddr  = ptr_q;
      memWdata = '0;
    end else if (access && we) begin
      memWe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWdata;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] parMem [DEPTH];
  logic [NB-1:0] rdPar, calcPar, mergedPar, parWdata;

  assign rdPar = parMem[addr];

  // Even parity per byte; injection flips byte 0 only when that byte is written.
  always_comb begin
    mergedPar = rdPar;
    calcPar   = '0;
    for (int i = 0; i < NB; i++) begin
      calcPar[i] = ^rdWord[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (be[i]) mergedPar[i] = ^din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    if (be[0] && par_inj) mergedPar[0] = ~mergedPar[0];
    parWdata = busy ? '0 : mergedPar;
  end

  always_ff @(posedge clk) begin
    if (memWe) parMem[memAddr] <= parWdata;
  end

  assign rdPerr = |(rdPar ^ calcPar);
`else
  logic unusedParInj;
  assign unusedParInj = par_inj;
  assign rdPerr       = 1'b0;
`endif

  always_comb begin
    s1Data_d  = s1Data_q;
    s1Valid_d = 1'b0;
    s1Perr_d  = 1'b0;
    if (access) begin
      if (!we) begin
        s1Data_d  = rdWord;
        s1Valid_d = 1'b1;
        s1Perr_d  = rdPerr;
      end else if (RD_MODE == 0) begin
        s1Data_d = rdWord;
      end else if (RD_MODE == 1) begin
        s1Data_d = mergedWord;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Data_q  <= '0;
      s1Valid_q <= 1'b0;
      s1Perr_q  <= 1'b0;
    end else begin
      s1Data_q  <= s1Data_d;
      s1Valid_q <= s1Valid_d;
      s1Perr_q  <= s1Perr_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic [DATA_WIDTH-1:0] s2Data_q;
      logic                  s2Valid_q, s2Perr_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2Data_q  <= '0;
          s2Valid_q <= 1'b0;
          s2Perr_q  <= 1'b0;
        end else begin
          s2Data_q  <= s1Data_q;
          s2Valid_q <= s1Valid_q;
          s2Perr_q  <= s1Perr_q;
        end
      end

      assign dout       = s2Data_q;
      assign dout_valid = s2Valid_q;
      assign parity_err = s2Perr_q;
    end else begin : gNoOutReg
      assign dout       = s1Data_q;
      assign dout_valid = s1Valid_q;
      assign parity_err = s1Perr_q;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench for sp_ram_be: three instances (READ_FIRST, WRITE_FIRST+OUT_REG,
// NO_CHANGE) share one stimulus stream and are checked against hand-computed values.
module tb_sp_ram_be;

`ifdef SP_RAM_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic        clk, rst, en, we, parInj;
  logic [3:0]  be;
  logic [7:0]  addr;
  logic [31:0] din;

  logic [31:0] doutA, doutB, doutC;
  logic        validA, validB, validC;
  logic        perrA, perrB, perrC;
  logic        busyA, busyB, busyC;

  int checks = 0;
  int errors = 0;

  sp_ram_be #(.RD_MODE(0), .OUT_REG(0)) dutA (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .par_inj(parInj), .dout(doutA), .dout_valid(validA), .parity_err(perrA), .busy(busyA)
  );

  sp_ram_be #(.RD_MODE(1), .OUT_REG(1)) dutB (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .par_inj(parInj), .dout(doutB), .dout_valid(validB), .parity_err(perrB), .busy(busyB)
  );

  sp_ram_be #(.RD_MODE(2), .OUT_REG(0)) dutC (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .par_inj(parInj), .dout(doutC), .dout_valid(validC), .parity_err(perrC), .busy(busyC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task applyStimulus(input logic e, input logic w, input logic [3:0] b,
                     input logic [7:0] a, input logic [31:0] d, input logic inj);
    @(negedge clk);
    en = e; we = w; be = b; addr = a; din = d; parInj = inj;
  endtask

  // Read one word; A and C answer after one edge, B after two.
  task readCheck(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic expPerr);
    applyStimulus(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0);
    checkOutput({tag, " A dout"}, doutA, exp);
    checkOutput({tag, " A valid"}, 32'(validA), 32'd1);
    checkOutput({tag, " A perr"}, 32'(perrA), 32'(expPerr));
    checkOutput({tag, " C dout"}, doutC, exp);
    checkOutput({tag, " C valid"}, 32'(validC), 32'd1);
    checkOutput({tag, " B early valid"}, 32'(validB), 32'd0);
    @(negedge clk);
    checkOutput({tag, " B dout"}, doutB, exp);
    checkOutput({tag, " B valid"}, 32'(validB), 32'd1);
    checkOutput({tag, " B perr"}, 32'(perrB), 32'(expPerr));
    checkOutput({tag, " A valid drop"}, 32'(validA), 32'd0);
  endtask

  task countBusy(input string tag);
    int n;
    n = 0;
    while (busyA && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    en = 1'b0; we = 1'b0;
    checkOutput({tag, " busy edges"}, 32'(n), 32'd256);
    checkOutput({tag, " B busy"}, 32'(busyB), 32'd0);
    checkOutput({tag, " C busy"}, 32'(busyC), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; be = 4'h0; addr = 8'h0; din = 32'h0; parInj = 1'b0;
    #1;
    checkOutput("reset A dout", doutA, 32'h0);
    checkOutput("reset A valid", 32'(validA), 32'd0);
    checkOutput("reset busy", 32'(busyA), 32'd1);
    checkOutput("reset B dout", doutB, 32'h0);
    checkOutput("reset perr", 32'(perrA), 32'd0);

    // Release reset with a write to 0x05 pending for the whole clear.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; we = 1'b1; be = 4'hF; addr = 8'h05; din = 32'hFFFFFFFF;
    checkOutput("busy valid", 32'(validA), 32'd0);
    countBusy("clear1");

    readCheck("rd00", 8'h00, 32'h0, 1'b0);
    readCheck("rd7F", 8'h7F, 32'h0, 1'b0);
    readCheck("rdFF", 8'hFF, 32'h0, 1'b0);
    readCheck("rd05 ignored", 8'h05, 32'h0, 1'b0);

    // Byte merge: back-to-back writes then immediate read.
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h10, 32'hAABBCCDD, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h5, 8'h10, 32'h11223344, 1'b0);
    readCheck("merge", 8'h10, 32'hAA22CC44, 1'b0);

    applyStimulus(1'b1, 1'b1, 4'h0, 8'h10, 32'h00000000, 1'b0);
    readCheck("be0", 8'h10, 32'hAA22CC44, 1'b0);

    // Read-during-write behaviour per mode.
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h20, 32'h12345678, 1'b0);
    readCheck("dout prime", 8'h10, 32'hAA22CC44, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h20, 32'hCAFEBABE, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0);
    checkOutput("rdw A read-first", doutA, 32'h12345678);
    checkOutput("rdw A valid", 32'(validA), 32'd0);
    checkOutput("rdw C no-change", doutC, 32'hAA22CC44);
    checkOutput("rdw C valid", 32'(validC), 32'd0);
    @(negedge clk);
    checkOutput("rdw B write-first", doutB, 32'hCAFEBABE);
    checkOutput("rdw B valid", 32'(validB), 32'd0);
    readCheck("rd20", 8'h20, 32'hCAFEBABE, 1'b0);

    // Parity injection and repair.
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h30, 32'h000000FF, 1'b1);
    readCheck("par inj", 8'h30, 32'h000000FF, PERR_EXP);
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h30, 32'h000000FF, 1'b0);
    readCheck("par ok", 8'h30, 32'h000000FF, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, 8'(i), 32'(i) * 32'h11111111, 1'b0);
    end

    // Streaming reads, then reset with reads still in flight.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 8'(i), 32'h0, 1'b0);
      if (i > 1) begin
        checkOutput("stream A", doutA, 32'(i - 1) * 32'h11111111);
        checkOutput("stream A valid", 32'(validA), 32'd1);
      end
      if (i > 2) begin
        checkOutput("stream B", doutB, 32'(i - 2) * 32'h11111111);
        checkOutput("stream B valid", 32'(validB), 32'd1);
      end
    end
    @(negedge clk);
    checkOutput("stream A last", doutA, 32'h44444444);
    checkOutput("stream B pen", doutB, 32'h33333333);
    rst = 1'b1; en = 1'b0;
    #1;
    checkOutput("midrst A dout", doutA, 32'h0);
    checkOutput("midrst A valid", 32'(validA), 32'd0);
    checkOutput("midrst B dout", doutB, 32'h0);
    checkOutput("midrst B valid", 32'(validB), 32'd0);
    checkOutput("midrst busy", 32'(busyA), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    countBusy("clear2");
    readCheck("rd01 cleared", 8'h01, 32'h0, 1'b0);
    readCheck("rd30 cleared", 8'h30, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
- Next-generation single-port synchronous RAM: per-byte write enables, selectable read-during-write mode, optional output pipeline stage, and a read-valid strobe.
- After every reset, a built-in clear engine zeroes all locations; the block stays busy until the clear completes.
- Used as a generic buffer and table store under FIFO and controller blocks in the memory subsystem.

Parameters:
- ADDR_WIDTH, 8: address bits. DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: write-enable granularity. NB = DATA_WIDTH/BYTE_WIDTH.
- RD_MODE, 0: read-during-write mode. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 1 adds an output register stage, giving read latency 2 instead of 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  access request.
- we  in  1  1 = write, 0 = read. Sampled only when en=1.
- be  in  NB  byte write enables. be[i] covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
- addr  in  ADDR_WIDTH  word address.
- din  in  DATA_WIDTH  write data.
- par_inj  in  1  parity error injection. Used only with PARITY_EN.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle strobe marking dout as new read data.
- parity_err  out  1  parity mismatch flag, aligned with dout_valid.
- busy  out  1  clear engine running; all requests are ignored.

Behaviour:
- Reset (async assert): dout=0, dout_valid=0, parity_err=0, busy=1, all pipeline registers=0, FSM=CLEAR, clear pointer=0. rst does not touch the memory array directly.
- FSM state CLEAR:
  - Each rising edge after rst release writes all-zero data (and zero parity) to mem[ptr], then ptr++.
  - The edge that writes DEPTH-1 moves the FSM to READY and drops busy.
  - busy is therefore high for exactly DEPTH edges after release.
- FSM state READY: the FSM stays here until the next rst.
- Requests while busy=1 (any state): ignored. No memory write, dout holds, dout_valid=0.
- Read (en=1, we=0, busy=0): captures mem[addr] into stage 1. dout_valid accompanies it.
- Write (en=1, we=1, busy=0):
  - Bytes with be[i]=1 take din; bytes with be[i]=0 keep their old value.
  - be=0 leaves memory unchanged but still counts as a write access.
  - dout update on write, by RD_MODE:
    - READ_FIRST: stage 1 takes the pre-write word.
    - WRITE_FIRST: stage 1 takes the merged post-write word.
    - NO_CHANGE: stage 1 holds.
  - dout_valid stays 0 on writes in all modes.
- en=0: memory unchanged, stage 1 holds, its valid bit=0.
- Latency:
  - OUT_REG=0: dout and dout_valid are stage 1 registers, so data appears 1 edge after the request.
  - OUT_REG=1: stage 2 copies stage 1 data and valid every edge, so data appears 2 edges after the request. Back-to-back reads stream one per cycle.
- Consecutive writes then a read to the same address on the next cycle: the read returns the latest written value. No hazard, since there is a single port.
- Reset mid-operation:
  - In-flight reads are discarded; valid bits clear immediately.
  - On release, clear restarts from address 0 regardless of where a previous clear stopped.

Optional Feature:
- Macro: SP_RAM_PARITY_EN.
- Defined:
  - Array is widened by NB bits of even parity, one per byte, written with each enabled byte.
  - When par_inj=1 on a write, stored parity of byte 0 is inverted, provided be[0]=1.
  - On read, parity is recomputed. parity_err=1 in the same cycle as dout_valid if any byte mismatches; otherwise 0.
  - Under OUT_REG, parity_err is pipelined with the data.
  - The clear engine writes correct parity (0).
- Undefined: no parity storage, par_inj ignored, parity_err tied 0.

Test Plan:
1. Reset, release, count busy-high edges -> exactly 256 (ADDR_WIDTH=8). Then read addr 0x00, 0x7F, 0xFF -> dout=0x00000000 each, dout_valid pulse each.
2. Write 0xAABBCCDD at addr 0x10 be=4'b1111, then write 0x11223344 be=4'b0101, then read 0x10 -> dout=0xAA22CC44, 1 edge after request (OUT_REG=0), 2 edges with OUT_REG=1.
3. addr 0x20 holds 0x12345678; write 0xCAFEBABE be=4'b1111:
   - RD_MODE=0 -> dout=0x12345678.
   - RD_MODE=1 -> dout=0xCAFEBABE.
   - RD_MODE=2 -> dout unchanged.
   - dout_valid=0 in all cases.
4. Issue en=1 we=1 to addr 0x05 with din=0xFFFFFFFF while busy=1; after clear completes, read 0x05 -> 0x00000000.
5. Back-to-back reads of 0x01..0x04 with OUT_REG=1, assert rst one edge after the last request -> dout=0 and dout_valid=0 immediately. After release busy=1 for 256 edges, then 0x01 reads 0.
6. With SP_RAM_PARITY_EN: write 0x000000FF with par_inj=1 at 0x30, read -> parity_err=1 with dout_valid. Rewrite with par_inj=0, read -> parity_err=0. Without the macro -> parity_err stays 0.
